tia_cpu_bus_receiver: RTL
=========================

# tia_cpu_bus_receiver

- Color-clock-domain receiver for the 6502 side of the TIA.
- Consumes `phi_theta` from the TIA divide-by-three, tracks the 3-color-clock CPU cycle phase, and captures CPU register writes as single-cycle strobes.
- Implements WSYNC (RDY hold until start of line) and issues the RSYNC request that feeds `rsyn` of the divider.

## Interface
Parameters:
- `WSYNC_ADDR`, 6'h02, register address that halts the CPU via `rdy`.
- `RSYNC_ADDR`, 6'h03, register address that pulses `rsyn`.

Ports (one clock; reset is synchronous and active-low):
- `clk` input 1: color clock; all logic on rising edge.
- `resn` input 1: synchronous active-low reset.
- `phi_theta` input 1: CPU clock from the divider; high for 1 of every 3 `clk` cycles when stable.
- `cs` input 1: TIA chip select, valid while `phi_theta` high.
- `rw` input 1: 1 = read, 0 = write.
- `a` input 6: register address.
- `d` input 8: write data.
- `hsync_start` input 1: one-`clk` pulse at horizontal count 0.
- `wr_stb` output 1: one-`clk` write strobe.
- `wr_addr` output 6: captured address, held until the next capture.
- `wr_data` output 8: captured data, held until the next capture.
- `rdy` output 1: CPU RDY; 0 halts the CPU.
- `rsyn` output 1: one-`clk` resync pulse to the divider.
- `phase` output 2: `clk` position within the CPU cycle (0, 1, 2).
- `locked` output 1: phase tracker locked.
- `phase_err` output 1: sticky phase-violation flag.

## Operation
Edge detection:
- Register `phi_theta` into `phi_q`.
- Rise = `phi_theta & ~phi_q`; fall = `~phi_theta & phi_q`.

Phase tracking:
- On rise, `phase` is set to 0.
- Otherwise `phase` increments 0→1→2 and holds at 2.
- A good rise is one seen while `phase`==2.
- `locked` sets after two consecutive good rises.
- `phase_err` sets, and `locked` clears, on a rise with `phase`≠2, or on no rise while `phase`==2 and `locked`=1.
- `phase_err` clears only on reset.

Write capture:
- On a fall with `cs`=1, `rw`=0 and `locked`=1, latch `a` and `d` into `wr_addr`/`wr_data`.
- Pulse `wr_stb` for exactly one cycle.
- A write is captured for every address, including the WSYNC and RSYNC addresses.
- Reads produce no action.

RSYNC:
- A captured write to `RSYNC_ADDR` pulses `rsyn` in the same cycle as `wr_stb`.

WSYNC state machine (states RUN, HALT, RELEASE):
- RUN: `rdy`=1. A captured write to `WSYNC_ADDR` → HALT.
- HALT: `rdy`=0. `hsync_start` → RELEASE.
- RELEASE: `rdy`=0. A rise → RUN. A WSYNC write → HALT.
- Writes are captured in every state, because the 6502 ignores RDY on write cycles. A WSYNC write while in HALT stays in HALT.

## Timing
Reset:
- `resn`=0 at a rising edge gives, next cycle: `phase`=0, `locked`=0, `phase_err`=0, `wr_stb`=0, `wr_addr`=0, `wr_data`=0, `rsyn`=0, `rdy`=1, state RUN, `phi_q`=0.
- Reset while in HALT releases `rdy` on the next cycle.

Latency:
- A fall detected at cycle N drives `wr_stb`, `rsyn` and the new `wr_addr`/`wr_data` during cycle N+1.
- `rdy` falls in cycle N+1 for a WSYNC write.

Release:
- `hsync_start` at cycle M moves HALT→RELEASE at M+1.
- The first rise detected at or after M+1, at cycle R, gives `rdy`=1 during R+1.

Simultaneous events:
- `hsync_start` in the same cycle as the fall that captures a WSYNC write is ignored; the release waits for the next line.
- A WSYNC write and a rise in RELEASE in the same cycle resolves to HALT.
- `hsync_start` while in RUN or RELEASE is ignored.

## Configuration
`TIA_BUS_PHASE_CHECK_EN`:
- Defined: phase checking, `locked` and `phase_err` behave as above, and writes are gated by `locked`.
- Undefined: `locked` is tied to 1 and `phase_err` to 0.
- Undefined: writes are captured on every qualifying fall, and `phase` still counts.

## Test plan
- Reset, then a stable 3-cycle `phi_theta` for 3 CPU cycles → `locked`=1 after the second good rise; `phase` sequence 0,1,2 repeats; `phase_err`=0.
- Write `a`=6'h0D, `d`=8'hA5 → single `wr_stb` one cycle after the fall; `wr_addr`=6'h0D and `wr_data`=8'hA5 held through the next 5 CPU cycles; `rsyn`=0.
- Write to 6'h02, then `hsync_start` 40 cycles later → `rdy`=0 from fall+1, returns to 1 the cycle after the first rise following `hsync_start`. Repeat with `hsync_start` coincident with the capturing fall → `rdy` stays 0 until the next `hsync_start`.
- Write to 6'h03 → `rsyn` and `wr_stb` both high for exactly one cycle, simultaneously.
- Inject a rise at `phase`=1 while locked → `phase_err`=1 (sticky), `locked`=0, and the next write is not captured. With the macro undefined, the same stimulus gives `phase_err`=0 and the write is captured.
- Assert `resn`=0 for one cycle while in HALT → `rdy`=1, `wr_stb`=0 and `locked`=0 next cycle.

Source files
------------

// File: rtl/tia_cpu_bus_receiver.sv
// CPU-bus receiver for the TIA colour-clock domain: phi_theta phase tracking, write capture, WSYNC/RSYNC.
// Optional phase checking is enabled with `define TIA_BUS_PHASE_CHECK_EN.
module tia_cpu_bus_receiver #(
    parameter logic [5:0] WSYNC_ADDR = 6'h02,
    parameter logic [5:0] RSYNC_ADDR = 6'h03
) (
    input  logic       clk,
    input  logic       resn,
    input  logic       phi_theta,
    input  logic       cs,
    input  logic       rw,
    input  logic [5:0] a,
    input  logic [7:0] d,
    input  logic       hsync_start,
    output logic       wr_stb,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rdy,
    output logic       rsyn,
    output logic [1:0] phase,
    output logic       locked,
    output logic       phase_err
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_RELEASE
    } state_t;

    state_t state_q, state_d;
    logic   phi_q;
    logic   rise, fall, capture, wsync_wr;

    assign rise     = phi_theta & ~phi_q;
    assign fall     = ~phi_theta & phi_q;
    assign capture  = fall & cs & ~rw & locked;
    assign wsync_wr = capture && (a == WSYNC_ADDR);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resn) begin
            phi_q <= 1'b0;
            phase <= 2'd0;
        end else begin
            phi_q <= phi_theta;
            if (rise)
                phase <= 2'd0;
            else if (phase != 2'd2)
                phase <= phase + 2'd1;
        end
    end

`ifdef TIA_BUS_PHASE_CHECK_EN
    logic good_seen;  // one good rise since lock was last lost

    always_ff @(posedge clk) begin
        if (!resn) begin
            locked    <= 1'b0;
            phase_err <= 1'b0;
            good_seen <= 1'b0;
        end else if (rise) begin
            if (phase == 2'd2) begin
                good_seen <= 1'b1;
                if (good_seen)
                    locked <= 1'b1;
            end else begin
                phase_err <= 1'b1;
                locked    <= 1'b0;
                good_seen <= 1'b0;
            end
        end else if (phase == 2'd2 && locked) begin
            phase_err <= 1'b1;
            locked    <= 1'b0;
            good_seen <= 1'b0;
        end
    end
`else
    assign locked    = 1'b1;
    assign phase_err = 1'b0;
`endif

    // Address and data are held between captures; the strobes last a single cycle.
    always_ff @(posedge clk) begin
        if (!resn) begin
            wr_stb  <= 1'b0;
            rsyn    <= 1'b0;
            wr_addr <= 6'd0;
            wr_data <= 8'd0;
        end else begin
            wr_stb <= capture;
            rsyn   <= capture && (a == RSYNC_ADDR);
            if (capture) begin
                wr_addr <= a;
                wr_data <= d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resn)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // NOTE: defaults first in always_comb so no path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                rdy = 1'b1;
                if (wsync_wr)
                    state_d = ST_HALT;
            end
            ST_HALT: begin
                if (!wsync_wr && hsync_start)
                    state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (wsync_wr)
                    state_d = ST_HALT;
                else if (rise)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

endmodule
